obi_data_mem_responder: RTL and testbench



---
 rtl/obi_data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_obi_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_data_mem_responder.sv
// OBI data-side memory responder: word storage with byte enables, grant delay FSM and
// in-order fixed-latency responses. Optional macro OBI_ADDR_ERR_EN adds data_err_i.
module obi_data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned GNT_DELAY   = 0,
  parameter int unsigned RSP_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_o,
  input  logic        data_we_o,
  input  logic [31:0] data_addr_o,
  input  logic [3:0]  data_be_o,
  input  logic [31:0] data_wdata_o,
  input  logic        gnt_stall,
  output logic        data_gnt_i,
  output logic        data_rvalid_i,
  output logic [31:0] data_rdata_i
`ifdef OBI_ADDR_ERR_EN
  ,
  output logic        data_err_i
`endif
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  GntDelay = 4'(GNT_DELAY);

  typedef enum logic [1:0] {StIdle, StWait, StGnt} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (data_req_o && !gnt_stall) begin
          if (GNT_DELAY == 0) begin
            state_d = StGnt;
          end else begin
            state_d = StWait;
            cnt_d   = 4'd1;
          end
        end
      end
      StWait: begin
        if (!data_req_o) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!gnt_stall) begin
          if (cnt_q == GntDelay) begin
            state_d = StGnt;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StGnt: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_gnt_i = (state_q == StGnt);

  logic            accept;
  logic            oob;
  logic            wr_en;
  logic [IdxW-1:0] idx;
  logic [31:0]     rsp_data;
  logic [31:0]     mem_q [DEPTH_WORDS];

  assign accept = data_req_o && (state_q == StGnt);
  assign idx    = data_addr_o[IdxW+1:2];

`ifdef OBI_ADDR_ERR_EN
  assign oob = |data_addr_o[31:IdxW+2];
`else
  assign oob = 1'b0;
`endif

  // Byte offset always ignored; upper bits only matter when range errors are enabled.
  logic unused_addr;
  assign unused_addr = ^{data_addr_o[1:0], data_addr_o[31:IdxW+2]};

  assign wr_en    = accept && data_we_o && !oob && !rst;
  assign rsp_data = (accept && !data_we_o && !oob) ? mem_q[idx] : 32'h0;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_o[i]) begin
          mem_q[idx][8*i +: 8] <= data_wdata_o[8*i +: 8];
        end
      end
    end
  end

  logic [RSP_LAT-1:0] pipe_valid_q;
  logic [31:0]        pipe_data_q [RSP_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < int'(RSP_LAT); i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      for (int i = int'(RSP_LAT) - 1; i > 0; i--) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
      pipe_valid_q[0] <= accept;
      pipe_data_q[0]  <= rsp_data;
    end
  end

  assign data_rvalid_i = pipe_valid_q[RSP_LAT-1];
  assign data_rdata_i  = pipe_data_q[RSP_LAT-1];

`ifdef OBI_ADDR_ERR_EN
  logic [RSP_LAT-1:0] pipe_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_err_q <= '0;
    end else begin
      for (int i = int'(RSP_LAT) - 1; i > 0; i--) begin
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
      pipe_err_q[0] <= accept && oob;
    end
  end

  assign data_err_i = pipe_err_q[RSP_LAT-1];
`endif

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Directed bench for obi_data_mem_responder: three instances (delay 0/lat 1, delay 3/lat 1,
// delay 0/lat 4) share one stimulus bus; each phase checks only the instance it targets.
module tb_obi_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, stall;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic        gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
  logic [31:0] rd_a, rd_b, rd_c;

`ifdef OBI_ADDR_ERR_EN
  logic err_a, err_b, err_c;
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_data_mem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(0), .RSP_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .data_req_o(req), .data_we_o(we), .data_addr_o(addr),
    .data_be_o(be), .data_wdata_o(wdata), .gnt_stall(stall),
    .data_gnt_i(gnt_a), .data_rvalid_i(rv_a), .data_rdata_i(rd_a)
`ifdef OBI_ADDR_ERR_EN
    , .data_err_i(err_a)
`endif
  );

  obi_data_mem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(3), .RSP_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .data_req_o(req), .data_we_o(we), .data_addr_o(addr),
    .data_be_o(be), .data_wdata_o(wdata), .gnt_stall(stall),
    .data_gnt_i(gnt_b), .data_rvalid_i(rv_b), .data_rdata_i(rd_b)
`ifdef OBI_ADDR_ERR_EN
    , .data_err_i(err_b)
`endif
  );

  obi_data_mem_responder #(.DEPTH_WORDS(1024), .GNT_DELAY(0), .RSP_LAT(4)) u_dut_c (
    .clk(clk), .rst(rst), .data_req_o(req), .data_we_o(we), .data_addr_o(addr),
    .data_be_o(be), .data_wdata_o(wdata), .gnt_stall(stall),
    .data_gnt_i(gnt_c), .data_rvalid_i(rv_c), .data_rdata_i(rd_c)
`ifdef OBI_ADDR_ERR_EN
    , .data_err_i(err_c)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_wrap;  // expected rdata when out-of-range addresses wrap
    logic [31:0] rd_err;   // expected rdata when out-of-range accesses are rejected
    logic        oob;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic gnt_of(input int sel);
    case (sel)
      0:       return gnt_a;
      1:       return gnt_b;
      default: return gnt_c;
    endcase
  endfunction

  // Raises a request at a negedge, holds it through the granted cycle, and reports grant
  // latency in cycles (-1 on timeout). Returns just after the accepting edge.
  task automatic issue(input int sel, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    lat = -1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (gnt_of(sel)) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] exp_rd;

    vecs[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0,        32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,   4'h5, 32'hAABBCCDD, 32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h24,   4'hF, 32'h0BADF00D, 32'h0,        32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h24,   4'h0, 32'h12345678, 32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h24,   4'h1, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h23,   4'hF, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[9]  = '{1'b1, 32'h0,    4'hF, 32'hCAFE0000, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h1000, 4'hF, 32'h5,        32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'h5,        32'hCAFE0000, 1'b0};
    vecs[12] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h5,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 32'h1002, 4'h8, 32'hEE000000, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'hEE000005, 32'hCAFE0000, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_gnt_a", gnt_a, 0); check("reset_rv_a", rv_a, 0); check("reset_rd_a", rd_a, 0);
    check("reset_gnt_b", gnt_b, 0); check("reset_rv_b", rv_b, 0); check("reset_rd_b", rd_b, 0);
    check("reset_gnt_c", gnt_c, 0); check("reset_rv_c", rv_c, 0); check("reset_rd_c", rd_c, 0);
`ifdef OBI_ADDR_ERR_EN
    check("reset_err_a", err_a, 0);
`endif

    // Table-driven single transactions on the zero-delay, latency-1 instance.
    for (int i = 0; i < NumVec; i++) begin
      issue(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, lat);
      exp_rd = ErrEn ? vecs[i].rd_err : vecs[i].rd_wrap;
      check($sformatf("vec%0d_gnt_lat", i), lat, 1);
      @(negedge clk);
      check($sformatf("vec%0d_rvalid", i), rv_a, 1);
      check($sformatf("vec%0d_rdata", i), rd_a, exp_rd);
      check($sformatf("vec%0d_gnt_pulse", i), gnt_a, 0);
`ifdef OBI_ADDR_ERR_EN
      check($sformatf("vec%0d_err", i), err_a, vecs[i].oob);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_rvalid_done", i), rv_a, 0);
      check($sformatf("vec%0d_rdata_idle", i), rd_a, 0);
    end

    // Grant delay of 3 with no stall.
    issue(1, 1'b1, 32'h30, 4'hF, 32'h5A5A1234, lat);
    check("b_write_gnt_lat", lat, 4);
    @(negedge clk);
    check("b_write_rvalid", rv_b, 1);
    check("b_write_rdata", rd_b, 0);

    // Grant delay of 3 with two stalled cycles mid-wait: grant 6 cycles after req rises.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h30; be = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("stall_gnt_c%0d", c), gnt_b, (c == 6) ? 32'd1 : 32'd0);
      if (c == 2) stall = 1'b1;
      if (c == 4) stall = 1'b0;
    end
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("stall_gnt_pulse", gnt_b, 0);
    check("stall_rvalid", rv_b, 1);
    check("stall_rdata", rd_b, 32'h5A5A1234);
    @(negedge clk);
    check("stall_rvalid_done", rv_b, 0);

    // Request withdrawn while waiting: no grant, and a fresh request sees the full delay.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h30;
    repeat (2) @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drop_gnt_%0d", k), gnt_b, 0);
    end
    issue(1, 1'b0, 32'h30, 4'hF, 32'h0, lat);
    check("drop_regnt_lat", lat, 4);
    @(negedge clk);
    check("drop_rdata", rd_b, 32'h5A5A1234);

    // Latency-4 instance: preload, then three reads granted every other cycle.
    issue(2, 1'b1, 32'h0, 4'hF, 32'd1, lat);
    issue(2, 1'b1, 32'h4, 4'hF, 32'd2, lat);
    issue(2, 1'b1, 32'h8, 4'hF, 32'd3, lat);
    repeat (6) @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
    @(negedge clk);
    for (int cyc = 0; cyc <= 8; cyc++) begin
      check($sformatf("b2b_gnt_%0d", cyc), gnt_c,
            (cyc == 0 || cyc == 2 || cyc == 4) ? 32'd1 : 32'd0);
      check($sformatf("b2b_rvalid_%0d", cyc), rv_c,
            (cyc == 4 || cyc == 6 || cyc == 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b_rdata_%0d", cyc), rd_c,
            (cyc == 4) ? 32'd1 : (cyc == 6) ? 32'd2 : (cyc == 8) ? 32'd3 : 32'd0);
      @(posedge clk);
      #1;
      if (cyc == 0) addr = 32'h4;
      if (cyc == 2) addr = 32'h8;
      if (cyc == 4) req = 1'b0;
      @(negedge clk);
    end

    // Reset two cycles after a granted read: its response must never appear.
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0, lat);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_rvalid_t%0d", k), rv_c, 0);
      check($sformatf("rstmid_rdata_t%0d", k), rd_c, 0);
      check($sformatf("rstmid_gnt_t%0d", k), gnt_c, 0);
    end

    // Reset in the granted cycle of a write: the write must be dropped.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; be = 4'hF; wdata = 32'h99;
    @(negedge clk);
    check("rstwr_gnt", gnt_c, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0; we = 1'b0;

    issue(2, 1'b0, 32'h8, 4'hF, 32'h0, lat);
    repeat (4) @(negedge clk);
    check("rstwr_rvalid", rv_c, 1);
    check("rstwr_mem_kept", rd_c, 32'd3);
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0, lat);
    repeat (4) @(negedge clk);
    check("rstmid_mem_kept", rd_c, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
